// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the core load/store path, port 1 the DMA/debug master.
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_resp,
  output logic        p0_err,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_resp,
  output logic        p1_err,
  output logic [31:0] p1_rdata,

  output logic        MemRW,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic               port_q;
  logic               err_q;
  logic               rd_ok_q;
  logic               memrw_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wd_q;

  logic               idle;
  logic               sel1;
  logic               any_gnt;
  logic               c_we;
  logic [31:0]        c_addr;
  logic [31:0]        c_wdata;
  logic               c_err;

  assign idle = (state_q == IDLE) && reset_n;

  // Port 1 wins a tie only when port 0 was granted last.
  assign sel1 = p1_req && (!p0_req || !last_q);

  assign p1_gnt  = idle && sel1;
  assign p0_gnt  = idle && p0_req && !sel1;
  assign any_gnt = p0_gnt || p1_gnt;

  always_comb begin
    c_we    = p0_we;
    c_addr  = p0_addr;
    c_wdata = p0_wdata;
    if (sel1) begin
      c_we    = p1_we;
      c_addr  = p1_addr;
      c_wdata = p1_wdata;
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) ||
                 (|c_addr[31:IDX_W+2]);

  assign MemRW     = memrw_q;
  assign Address   = {{(32-IDX_W){1'b0}}, idx_q};
  assign WriteData = wd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      memrw_q  <= 1'b0;
      idx_q    <= '0;
      wd_q     <= '0;
      p0_resp  <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_resp  <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          p0_resp <= 1'b0;
          p0_err  <= 1'b0;
          p1_resp <= 1'b0;
          p1_err  <= 1'b0;
          if (any_gnt) begin
            state_q <= ACCESS;
            last_q  <= sel1;
            port_q  <= sel1;
            err_q   <= c_err;
            rd_ok_q <= !c_we && !c_err;
            memrw_q <= c_we && !c_err;
            idx_q   <= c_addr[IDX_W+1:2];
            wd_q    <= (c_we && !c_err) ? c_wdata : '0;
          end
        end
        ACCESS: begin
          state_q <= IDLE;
          memrw_q <= 1'b0;
          idx_q   <= '0;
          wd_q    <= '0;
          if (port_q) begin
            p1_resp  <= 1'b1;
            p1_err   <= err_q;
            p1_rdata <= rd_ok_q ? ReadData : '0;
          end else begin
            p0_resp  <= 1'b1;
            p0_err   <= err_q;
            p0_rdata <= rd_ok_q ? ReadData : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word memory.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p0_gnt, p0_resp, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_resp, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        MemRW;
  logic [31:0] Address, WriteData, ReadData;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_resp(p0_resp),
    .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_resp(p1_resp),
    .p1_err(p1_err), .p1_rdata(p1_rdata),
    .MemRW(MemRW), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData)
  );

  assign ReadData = mem[Address[9:0]];
  always @(posedge clk) if (MemRW) mem[Address[9:0]] <= WriteData;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({p0_gnt, p1_gnt, p0_resp, p1_resp, p0_err, p1_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {p0_gnt, p1_gnt, p0_resp, p1_resp, p0_err, p1_err});
    end
    checks++;
    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h exp 0", p0_rdata, p1_rdata);
    end
    checks++;
    if (MemRW !== 1'b0 || Address !== 32'h0 || WriteData !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got %b %h %h exp 0", MemRW, Address, WriteData);
    end
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    next_cycle();
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_gnt got %b exp 1", p0_gnt);
    end
    next_cycle();
    p0_req = 0;
    #1;
    checks++;
    if (MemRW !== 1'b1 || Address !== 32'd4 || WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_mem got %b %h %h exp 1 00000004 deadbeef",
               MemRW, Address, WriteData);
    end
    next_cycle();
    #1;
    checks++;
    if (p0_resp !== 1'b1 || p0_err !== 1'b0) begin
      errors++; $display("FAIL wr_resp got %b%b exp 10", p0_resp, p0_err);
    end
    next_cycle();
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    #1;
    checks++;
    if (p0_resp !== 1'b0 || p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rd_gnt resp=%b gnt=%b exp resp 0 gnt 1", p0_resp, p0_gnt);
    end
    next_cycle();
    p0_req = 0;
    next_cycle();
    #1;
    checks++;
    if (p0_resp !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_resp got %b%b %h exp 10 deadbeef",
               p0_resp, p0_err, p0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic e0, e1;
    reset_n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    next_cycle();
    reset_n = 1;
    #1;
    for (int c = 0; c < 8; c++) begin
      e0 = (c % 4 == 0);
      e1 = (c % 4 == 2);
      checks++;
      if (p0_gnt !== e0 || p1_gnt !== e1) begin
        errors++;
        $display("FAIL rr_gnt cycle %0d got %b%b exp %b%b",
                 c, p0_gnt, p1_gnt, e0, e1);
      end
      if (c == 4) begin
        checks++;
        if (p1_resp !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rr_p1_rdata got %b %h exp 1 deadbeef",
                   p1_resp, p1_rdata);
        end
      end
      next_cycle();
      #1;
    end
    p0_req = 0; p1_req = 0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_errors();
    p1_req = 1; p1_we = 1; p1_addr = 32'h12; p1_wdata = 32'h11111111;
    #1;
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++; $display("FAIL mis_gnt got %b exp 1", p1_gnt);
    end
    next_cycle();
    p1_req = 0;
    #1;
    checks++;
    if (MemRW !== 1'b0) begin
      errors++; $display("FAIL mis_memrw got %b exp 0", MemRW);
    end
    next_cycle();
    #1;
    checks++;
    if (p1_resp !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mis_resp got %b%b %h exp 11 0", p1_resp, p1_err, p1_rdata);
    end
    p1_req = 1; p1_we = 1; p1_addr = 32'h1000; p1_wdata = 32'h22222222;
    #1;
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++; $display("FAIL oor_gnt got %b exp 1", p1_gnt);
    end
    next_cycle();
    p1_req = 0;
    #1;
    checks++;
    if (MemRW !== 1'b0) begin
      errors++; $display("FAIL oor_memrw got %b exp 0", MemRW);
    end
    next_cycle();
    #1;
    checks++;
    if (p1_resp !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_resp got %b%b %h exp 11 0", p1_resp, p1_err, p1_rdata);
    end
    p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    next_cycle();
    p1_req = 0;
    next_cycle();
    #1;
    checks++;
    if (p1_err !== 1'b0 || p1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mis_readback got %b %h exp 0 deadbeef", p1_err, p1_rdata);
    end
    p1_req = 1; p1_we = 0; p1_addr = 32'h0;
    next_cycle();
    p1_req = 0;
    next_cycle();
    #1;
    checks++;
    if (p1_err !== 1'b0 || p1_rdata !== 32'hA5000000) begin
      errors++;
      $display("FAIL oor_readback got %b %h exp 0 a5000000", p1_err, p1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_wait_access();
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    #1;
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++; $display("FAIL wait_p1_gnt got %b exp 1", p1_gnt);
    end
    next_cycle();
    p1_req = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h8;
    #1;
    checks++;
    if (p0_gnt !== 1'b0) begin
      errors++; $display("FAIL wait_p0_held got %b exp 0", p0_gnt);
    end
    next_cycle();
    #1;
    checks++;
    if (p1_resp !== 1'b1 || p0_gnt !== 1'b1 || p1_rdata !== 32'hA5000001) begin
      errors++;
      $display("FAIL wait_b2b got resp=%b gnt=%b %h exp 1 1 a5000001",
               p1_resp, p0_gnt, p1_rdata);
    end
    next_cycle();
    p0_req = 0;
    next_cycle();
    #1;
    checks++;
    if (p0_resp !== 1'b1 || p0_rdata !== 32'hA5000002) begin
      errors++;
      $display("FAIL wait_p0_resp got %b %h exp 1 a5000002", p0_resp, p0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hCAFEF00D;
    next_cycle();
    p0_req = 0;
    #1;
    checks++;
    if (MemRW !== 1'b1 || Address !== 32'd8) begin
      errors++;
      $display("FAIL rst_pre got %b %h exp 1 00000008", MemRW, Address);
    end
    reset_n = 0;
    #1;
    checks++;
    if (MemRW !== 1'b0 || Address !== 32'h0 || WriteData !== 32'h0) begin
      errors++;
      $display("FAIL rst_drop got %b %h %h exp 0 0 0", MemRW, Address, WriteData);
    end
    next_cycle();
    #1;
    checks++;
    if (p0_resp !== 1'b0 || p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_noresp got %b %h exp 0 0", p0_resp, p0_rdata);
    end
    reset_n = 1;
    next_cycle();
    p0_req = 1; p0_we = 0; p0_addr = 32'h20;
    next_cycle();
    p0_req = 0;
    next_cycle();
    #1;
    checks++;
    if (p0_resp !== 1'b1 || p0_rdata !== 32'hA5000008) begin
      errors++;
      $display("FAIL rst_readback got %b %h exp 1 a5000008", p0_resp, p0_rdata);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | i;
    reset_n = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_errors();
    test_wait_access();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. Shares the memory between the core load/store path (port 0) and a DMA/debug master (port 1) using round-robin grants and a req/gnt/resp handshake. Converts byte addresses to word indices, rejects misaligned or out-of-range accesses, and registers read data back to the winning requester.

## Interface
- DEPTH, 1024, memory depth in 32-bit words; power of two
- IDX_W, $clog2(DEPTH), width of the word index
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pN_req (N=0,1)  in  1  request valid; held with command until granted
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  32  byte address
- pN_wdata  in  32  write data
- pN_gnt  out  1  command accepted this cycle (req & gnt)
- pN_resp  out  1  one-cycle completion pulse (read or write)
- pN_err  out  1  valid with pN_resp; access was rejected
- pN_rdata  out  32  read data, valid with pN_resp on reads
- MemRW  out  1  to memory: 1 = write this cycle
- Address  out  32  to memory: word index, zero-extended from IDX_W
- WriteData  out  32  to memory
- ReadData  in  32  from memory, combinational on Address when MemRW = 0

## Operation
- FSM: IDLE, ACCESS.
- IDLE: if any pN_req, assert gnt to the winner (combinational), latch we, addr, wdata, port id and error flag, go to ACCESS. Otherwise stay.
- Arbitration: a single requester wins. When both request, the port not granted last wins. The last-granted pointer updates only on a grant; its reset value makes port 0 win the first tie.
- Error flag: addr[1:0] != 0 or addr >= 4*DEPTH.
- ACCESS: drive memory from the latched command. Address = addr[IDX_W+1:2]. For a legal write, MemRW = 1 and WriteData = wdata. Reads and errored commands keep MemRW = 0.
- On the ACCESS→IDLE edge, capture rdata: ReadData for a legal read, else 0. Capture resp/err for the latched port. Always return to IDLE.
- Outside ACCESS: MemRW = 0, Address = 0, WriteData = 0.
- gnt is asserted only in IDLE, so a port requesting during ACCESS waits. Requesters must not change the command while req is high and gnt is low.

## Timing
- Reset values: state IDLE, pointer = port 1 (port 0 favoured), all gnt/resp/err = 0, all rdata = 0, MemRW = 0, Address = 0, WriteData = 0.
- Cycle N: gnt. Cycle N+1: ACCESS, memory driven; a write commits at the end of N+1. Cycle N+2: resp pulses for exactly one cycle, with err/rdata.
- rdata holds its value until the next response to that port.
- Throughput: one access per 2 cycles. The IDLE cycle carrying resp may grant the next request, back-to-back.
- Simultaneous req: at most one gnt per cycle; the loser keeps req and is granted in the next IDLE.
- Same-port re-request: a port may raise req in its resp cycle. It is granted only if the other port is idle or was served last.
- Reset mid-ACCESS: state drops to IDLE immediately and MemRW goes to 0. A write not yet clocked is dropped and no resp is issued.
- Errored access: no memory write, resp + err at N+2, rdata = 0.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to byte 0x10. Expect gnt at N, MemRW = 1 with Address = 4 at N+1, p0_resp at N+2, p0_err = 0. A later p0 read of 0x10 returns 0xDEADBEEF at N+2.
- p0 and p1 both hold read req continuously from reset. Expect grants p0, p1, p0, p1 on every other cycle. No cycle has both gnt high.
- p1 writes byte 0x12 (misaligned), then byte 0x1000 (out of range with DEPTH = 1024). Expect p1_resp + p1_err each time, MemRW = 0 throughout, and memory unchanged on read-back.
- p0 read issued while p1 is in ACCESS. Expect p0_gnt delayed until the cycle of p1_resp, then p0_resp two cycles later.
- Assert reset_n low during ACCESS of a p0 write to 0x20. Expect MemRW to fall at once, no p0_resp, outputs at reset values, and a later read of 0x20 does not return the write data.
